corelet_ctrl: RTL and testbench
===============================

CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, meaning PE rows and weight vectors per kernel position.
REQ-002 SHALL have parameter col, default 8, meaning PE columns and weight drain cycles.
REQ-003 SHALL have parameter len_nij, default 16, meaning activation vectors per kernel position; must be <= OFIFO depth.
REQ-004 SHALL have parameter len_kij, default 9, meaning kernel positions per run.
REQ-005 SHALL have parameter w_base, default 1024, meaning xmem base address of the weights.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, run request sampled in IDLE.
REQ-009 SHALL have port ofifo_valid, input, 1, meaning the output FIFO holds a full row.
REQ-010 SHALL have port inst, output, 37, the corelet instruction bus.
REQ-011 SHALL have ports xmem_cen and xmem_wen, output, 1 each, active-low input SRAM chip and write enables.
REQ-012 SHALL have port xmem_addr, output, 11, input SRAM address.
REQ-013 SHALL have ports pmem_cen and pmem_wen, output, 1 each, active-low psum SRAM enables.
REQ-014 SHALL have port pmem_addr, output, 11, psum SRAM address.
REQ-015 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-016 SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-017 inst bit map SHALL be: 0 load, 1 execute, 2 l0_wr, 3 l0_rd, 4 ififo_rd, 5 ififo_wr, 6 ofifo_rd, 33 acc, 34 relu, 35 os_mode, 36 flush.
REQ-018 Bits 4, 5, 32:7 and 36:33 SHALL be 0 at all times (weight-stationary only).
REQ-019 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-020 States SHALL be IDLE, W_FILL, W_LOAD, W_DRAIN, A_FILL, EXEC, O_READ and DONE; a 4-bit kij counter and a step counter SHALL be kept.
REQ-021 IDLE: on start=1, clear kij and go to W_FILL; otherwise hold.
REQ-022 W_FILL SHALL last row+1 cycles; step k<row drives xmem_cen=0, xmem_wen=1 and xmem_addr=w_base+kij*row+k; steps 1..row drive l0_wr=1 (one cycle of SRAM read latency).
REQ-023 W_LOAD SHALL last row cycles with load=1 and l0_rd=1.
REQ-024 W_DRAIN SHALL last col cycles with inst all zero.
REQ-025 A_FILL SHALL last len_nij+1 cycles; it reads xmem_addr=k for k<len_nij and drives l0_wr=1 on steps 1..len_nij.
REQ-026 EXEC SHALL last len_nij cycles with execute=1 and l0_rd=1.
REQ-027 O_READ SHALL drive ofifo_rd=1 in any cycle where ofifo_valid=1 and fewer than len_nij reads have been issued.
REQ-028 One cycle after each read, O_READ SHALL drive pmem_cen=0, pmem_wen=0 and pmem_addr=kij*len_nij+n, where n is the read index.
REQ-029 O_READ SHALL exit after the final pmem write; if kij+1<len_kij, increment kij and go to W_FILL, else go to DONE.
REQ-030 O_READ SHALL wait indefinitely while ofifo_valid=0; there SHALL be no timeout.
REQ-031 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-032 start SHALL be ignored outside IDLE; start held high in DONE SHALL NOT restart the run until IDLE.
REQ-033 Address arithmetic SHALL be unsigned, 11 bits, truncating on overflow.
REQ-034 When idle, xmem_cen=1, pmem_cen=1, xmem_wen=1, pmem_wen=1 and both addresses hold their last value.

Reset
REQ-035 reset=1 at a rising edge SHALL force: state IDLE, counters 0, inst=0, xmem_cen=xmem_wen=pmem_cen=pmem_wen=1, both addresses 0, busy=0, done=0.
REQ-036 Reset asserted in any state SHALL abort the run with no further SRAM access; the first cycle after release is IDLE.

Verification
REQ-037 Idle/reset: reset 2 cycles with start=0 -> inst=0, busy=0, both cen=1 and done never pulses.
REQ-038 Single kij (len_kij=1): start pulse with ofifo_valid=1 -> cycle counts are W_FILL 9, W_LOAD 8, W_DRAIN 8, A_FILL 17, EXEC 16, O_READ 17 and DONE 1; pmem addresses 0..15; done rises exactly once.
REQ-039 Full run (len_kij=9): the weight address at kij=3, step 0 is 1048, and the final pmem address is 143.
REQ-040 Backpressure: ofifo_valid toggled 1-0-0-1... in O_READ -> ofifo_rd only when valid, 16 reads total, and no pmem write without a preceding read.
REQ-041 Mid-run reset: reset in EXEC step 5 -> next cycle inst=0 and busy=0; a fresh start replays from kij=0.
REQ-042 start held high throughout -> start is ignored while busy; a new run begins the cycle after IDLE is reached.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Weight-stationary corelet sequencer: per kernel position it loads weights, streams
// activations, drains the output FIFO into psum SRAM. Every output is a registered decode.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 16,
  parameter int len_kij = 9,
  parameter int w_base  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [36:0] inst,
  output logic        xmem_cen,
  output logic        xmem_wen,
  output logic [10:0] xmem_addr,
  output logic        pmem_cen,
  output logic        pmem_wen,
  output logic [10:0] pmem_addr,
  output logic        busy,
  output logic        done
);

  localparam int M1   = (row + 1 > col) ? row + 1 : col;
  localparam int SMAX = (M1 > len_nij + 1) ? M1 : len_nij + 1;
  localparam int SW   = $clog2(SMAX + 1);
  localparam logic [SW-1:0] ROW_S = SW'(row);
  localparam logic [SW-1:0] COL_S = SW'(col);
  localparam logic [SW-1:0] NIJ_S = SW'(len_nij);
  localparam logic [SW-1:0] ONE_S = SW'(1);

  typedef enum logic [2:0] {
    IDLE, W_FILL, W_LOAD, W_DRAIN, A_FILL, EXEC, O_READ, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0]  kij_q, kij_d;
  logic        wr_pend_q, wr_pend_d;
  logic [SW-1:0] wr_idx_q, wr_idx_d;

  logic [36:0] inst_q, inst_d;
  logic        xmem_cen_q, xmem_cen_d, xmem_wen_q, xmem_wen_d;
  logic [10:0] xmem_addr_q, xmem_addr_d;
  logic        pmem_cen_q, pmem_cen_d, pmem_wen_q, pmem_wen_d;
  logic [10:0] pmem_addr_q, pmem_addr_d;
  logic        busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    kij_d       = kij_q;
    wr_pend_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    inst_d      = '0;
    xmem_cen_d  = 1'b1;
    xmem_wen_d  = 1'b1;
    xmem_addr_d = xmem_addr_q;
    pmem_cen_d  = 1'b1;
    pmem_wen_d  = 1'b1;
    pmem_addr_d = pmem_addr_q;
    busy_d      = (state_q != IDLE);
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kij_d   = '0;
          step_d  = '0;
          state_d = W_FILL;
        end
      end
      W_FILL: begin
        // L0 write trails the SRAM read by one cycle of read latency
        if (step_q < ROW_S) begin
          xmem_cen_d  = 1'b0;
          xmem_addr_d = 11'(w_base + 32'(kij_q) * row + 32'(step_q));
        end
        if (step_q != '0) inst_d[2] = 1'b1;
        if (step_q == ROW_S) begin
          step_d  = '0;
          state_d = W_LOAD;
        end else begin
          step_d = step_q + ONE_S;
        end
      end
      W_LOAD: begin
        inst_d[0] = 1'b1;
        inst_d[3] = 1'b1;
        if (step_q == ROW_S - ONE_S) begin
          step_d  = '0;
          state_d = W_DRAIN;
        end else begin
          step_d = step_q + ONE_S;
        end
      end
      W_DRAIN: begin
        if (step_q == COL_S - ONE_S) begin
          step_d  = '0;
          state_d = A_FILL;
        end else begin
          step_d = step_q + ONE_S;
        end
      end
      A_FILL: begin
        if (step_q < NIJ_S) begin
          xmem_cen_d  = 1'b0;
          xmem_addr_d = 11'(step_q);
        end
        if (step_q != '0) inst_d[2] = 1'b1;
        if (step_q == NIJ_S) begin
          step_d  = '0;
          state_d = EXEC;
        end else begin
          step_d = step_q + ONE_S;
        end
      end
      EXEC: begin
        inst_d[1] = 1'b1;
        inst_d[3] = 1'b1;
        if (step_q == NIJ_S - ONE_S) begin
          step_d  = '0;
          state_d = O_READ;
        end else begin
          step_d = step_q + ONE_S;
        end
      end
      O_READ: begin
        // step counts reads issued; each read is followed next cycle by its psum write
        if (ofifo_valid && (step_q < NIJ_S)) begin
          inst_d[6] = 1'b1;
          wr_pend_d = 1'b1;
          wr_idx_d  = step_q;
          step_d    = step_q + ONE_S;
        end
        if (wr_pend_q) begin
          pmem_cen_d  = 1'b0;
          pmem_wen_d  = 1'b0;
          pmem_addr_d = 11'(32'(kij_q) * len_nij + 32'(wr_idx_q));
          if (wr_idx_q == NIJ_S - ONE_S) begin
            step_d = '0;
            if (32'(kij_q) + 32'd1 < len_kij) begin
              kij_d   = kij_q + 4'd1;
              state_d = W_FILL;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      kij_q       <= '0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      inst_q      <= '0;
      xmem_cen_q  <= 1'b1;
      xmem_wen_q  <= 1'b1;
      xmem_addr_q <= '0;
      pmem_cen_q  <= 1'b1;
      pmem_wen_q  <= 1'b1;
      pmem_addr_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      kij_q       <= kij_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      inst_q      <= inst_d;
      xmem_cen_q  <= xmem_cen_d;
      xmem_wen_q  <= xmem_wen_d;
      xmem_addr_q <= xmem_addr_d;
      pmem_cen_q  <= pmem_cen_d;
      pmem_wen_q  <= pmem_wen_d;
      pmem_addr_q <= pmem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst      = inst_q;
  assign xmem_cen  = xmem_cen_q;
  assign xmem_wen  = xmem_wen_q;
  assign xmem_addr = xmem_addr_q;
  assign pmem_cen  = pmem_cen_q;
  assign pmem_wen  = pmem_wen_q;
  assign pmem_addr = pmem_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench: a per-cycle model of the expected output trace is queued as stimulus
// is applied and compared against the registered outputs after each rising edge.
module tb_corelet_ctrl;

  localparam int ROW = 8, COL = 8, NIJ = 16, LEN_KIJ = 9, W_BASE = 1024;

  typedef struct packed {
    logic        rst, st, vld;
    logic [1:0]  mark;
    logic [36:0] inst;
    logic        xcen, xwen;
    logic [10:0] xaddr;
    logic        pcen, pwen;
    logic [10:0] paddr;
    logic        busy, done;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [36:0] inst;
  logic        xmem_cen, xmem_wen, pmem_cen, pmem_wen, busy, done;
  logic [10:0] xmem_addr, pmem_addr;

  corelet_ctrl #(.row(ROW), .col(COL), .len_nij(NIJ), .len_kij(LEN_KIJ), .w_base(W_BASE)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xmem_addr(xmem_addr),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_addr(pmem_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  ent_t stim_q[$];
  ent_t exp_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   exp_rd, exp_done, obs_rd, obs_done;
  logic [10:0] m_xaddr = '0, m_paddr = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, got, want);
    end
  endtask

  function automatic ent_t base(input logic b, input logic hold, input int vmode);
    ent_t e;
    e = '0;
    e.st = hold; e.vld = (vmode == 0);
    e.xcen = 1'b1; e.xwen = 1'b1; e.xaddr = m_xaddr;
    e.pcen = 1'b1; e.pwen = 1'b1; e.paddr = m_paddr;
    e.busy = b;
    return e;
  endfunction

  task automatic push_idle(input logic st);
    ent_t e;
    e = base(1'b0, st, 1);
    stim_q.push_back(e);
  endtask

  task automatic push_reset();
    ent_t e;
    e = '0;
    e.rst = 1'b1; e.xcen = 1'b1; e.xwen = 1'b1; e.pcen = 1'b1; e.pwen = 1'b1;
    m_xaddr = '0; m_paddr = '0;
    stim_q.push_back(e);
  endtask

  // vmode 0: ofifo_valid always 1; vmode 1: 1-0-0 repeating inside O_READ
  task automatic gen_run(input int vmode, input logic hold, input logic abort);
    ent_t e;
    int reads, pidx, pidx_n, c;
    logic pend, npend, v, fin;
    e = base(1'b0, 1'b1, vmode);
    stim_q.push_back(e);
    for (int kij = 0; kij < LEN_KIJ; kij++) begin
      for (int k = 0; k <= ROW; k++) begin
        e = base(1'b1, hold, vmode);
        if (k < ROW) begin
          e.xcen = 1'b0; e.xaddr = 11'(W_BASE + kij * ROW + k); m_xaddr = e.xaddr;
          if (kij == 3 && k == 0) e.mark = 2'd1;
        end
        if (k >= 1) e.inst[2] = 1'b1;
        stim_q.push_back(e);
      end
      for (int k = 0; k < ROW; k++) begin
        e = base(1'b1, hold, vmode); e.inst[0] = 1'b1; e.inst[3] = 1'b1;
        stim_q.push_back(e);
      end
      for (int k = 0; k < COL; k++) stim_q.push_back(base(1'b1, hold, vmode));
      for (int k = 0; k <= NIJ; k++) begin
        e = base(1'b1, hold, vmode);
        if (k < NIJ) begin e.xcen = 1'b0; e.xaddr = 11'(k); m_xaddr = e.xaddr; end
        if (k >= 1) e.inst[2] = 1'b1;
        stim_q.push_back(e);
      end
      for (int k = 0; k < NIJ; k++) begin
        if (abort && k == 5) begin
          push_reset();
          push_idle(1'b0);
          return;
        end
        e = base(1'b1, hold, vmode); e.inst[1] = 1'b1; e.inst[3] = 1'b1;
        stim_q.push_back(e);
      end
      reads = 0; pend = 1'b0; pidx = 0; pidx_n = 0; c = 0;
      while (c < 400) begin
        v = (vmode == 0) ? 1'b1 : ((c % 3) == 0);
        e = base(1'b1, hold, vmode); e.vld = v;
        fin = 1'b0;
        if (pend) begin
          e.pcen = 1'b0; e.pwen = 1'b0; e.paddr = 11'(kij * NIJ + pidx); m_paddr = e.paddr;
          fin = (pidx == NIJ - 1);
          if (fin && kij == LEN_KIJ - 1) e.mark = 2'd2;
        end
        npend = 1'b0;
        if (v && reads < NIJ) begin
          e.inst[6] = 1'b1; npend = 1'b1; pidx_n = reads; reads++; exp_rd++;
        end
        stim_q.push_back(e);
        if (fin) break;
        pend = npend;
        if (npend) pidx = pidx_n;
        c++;
      end
    end
    e = base(1'b1, hold, vmode); e.done = 1'b1; exp_done++;
    stim_q.push_back(e);
  endtask

  task automatic exec_all(input string name);
    ent_t e, x;
    int n;
    n = 0;
    while (stim_q.size() > 0) begin
      e = stim_q.pop_front();
      reset = e.rst; start = e.st; ofifo_valid = e.vld;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      cyc++; n++;
      x = exp_q.pop_front();
      check_eq("inst", 64'(inst), 64'(x.inst));
      check_eq("xmem", 64'({xmem_cen, xmem_wen, xmem_addr}), 64'({x.xcen, x.xwen, x.xaddr}));
      check_eq("pmem", 64'({pmem_cen, pmem_wen, pmem_addr}), 64'({x.pcen, x.pwen, x.paddr}));
      check_eq("busy_done", 64'({busy, done}), 64'({x.busy, x.done}));
      if (x.mark == 2'd1) check_eq("w_addr_kij3", 64'(xmem_addr), 64'd1048);
      if (x.mark == 2'd2) check_eq("last_paddr", 64'(pmem_addr), 64'd143);
      if (inst[6]) obs_rd++;
      if (done) obs_done++;
    end
    check_eq({name, "_reads"}, 64'(obs_rd), 64'(exp_rd));
    check_eq({name, "_done"}, 64'(obs_done), 64'(exp_done));
    $display("run %s: cycles=%0d reads=%0d done_pulses=%0d", name, n, obs_rd, obs_done);
  endtask

  task automatic clear_counts();
    exp_rd = 0; exp_done = 0; obs_rd = 0; obs_done = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    clear_counts();
    push_reset(); push_reset(); push_idle(1'b0); push_idle(1'b0);
    exec_all("reset_idle");

    clear_counts();
    gen_run(0, 1'b0, 1'b0);
    exec_all("full_run");

    clear_counts();
    gen_run(1, 1'b0, 1'b0);
    exec_all("backpressure");

    clear_counts();
    gen_run(0, 1'b0, 1'b1);
    gen_run(0, 1'b0, 1'b0);
    exec_all("midrun_reset_replay");

    clear_counts();
    gen_run(0, 1'b1, 1'b0);
    gen_run(0, 1'b1, 1'b0);
    push_idle(1'b0); push_idle(1'b0);
    exec_all("start_held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
